// File: rtl/qcv_rf_pkg.sv
// Shared definitions for the multi-port integer register file:
// state encoding, default widths and the write-port priority helper.
package qcv_rf_pkg;

   typedef enum logic {
      RF_INIT,
      RF_READY
   } rf_state_e;

   localparam int RF_DATA_W    = 32;
   localparam int RF_ADDR_W    = 5;
   // Widest write-port hit vector the priority helper understands.
   localparam int RF_MAX_WRITE = 8;

   // Returns the highest-index set bit of a per-port hit vector, or -1 when
   // no port targets the address; the highest index always wins collisions.
   function automatic int rf_write_sel(input logic [RF_MAX_WRITE-1:0] hits);
      int sel;
      sel = -1;
      for (int j = 0; j < RF_MAX_WRITE; j++) begin
         if (hits[j]) begin
            sel = j;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/qcv_rf_scoreboard.sv
// Busy scoreboard for the register file: one bit per entry that is set when
// a producer is allocated and cleared when a writeback lands.
module qcv_rf_scoreboard
   import qcv_rf_pkg::*;
#(
   parameter int ADDR_W    = RF_ADDR_W,
   parameter int NUM_WRITE = 2,
   parameter int NUM_READ  = 2,
   parameter int ZERO_REG  = 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          en_i,
   input  logic [NUM_WRITE-1:0]          we_i,
   input  logic [NUM_WRITE*ADDR_W-1:0]   waddr_i,
   input  logic                          alloc_valid_i,
   input  logic [ADDR_W-1:0]             alloc_addr_i,
   input  logic [NUM_READ*ADDR_W-1:0]    raddr_i,
   output logic [NUM_READ-1:0]           rbusy_o
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busyNext;

   // Releases from writebacks first, then the new allocation, so a producer
   // issued in the same cycle as an older writeback keeps the entry busy.
   always_comb begin
      w_busyNext = r_busy;
      for (int j = 0; j < NUM_WRITE; j++) begin
         if (we_i[j]) begin
            w_busyNext[waddr_i[j*ADDR_W +: ADDR_W]] = 1'b0;
         end
      end
      if (alloc_valid_i) begin
         w_busyNext[alloc_addr_i] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         w_busyNext[0] = 1'b0;
      end
   end

   // Busy vector only moves while the file is ready; reset clears everything.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_busy <= '0;
      end else if (en_i) begin
         r_busy <= w_busyNext;
      end
   end

   // Read ports see registered busy state only.
   always_comb begin
      rbusy_o = '0;
      for (int k = 0; k < NUM_READ; k++) begin
         rbusy_o[k] = r_busy[raddr_i[k*ADDR_W +: ADDR_W]];
      end
   end

endmodule

// File: rtl/qcv_regfile_mp.sv
// Parametrised multi-port integer register file with busy scoreboard and a
// self-clearing INIT sequence after reset.
// Optional build macro QCV_RF_BYPASS_EN: same-cycle write-to-read bypass of
// data and busy release.
module qcv_regfile_mp
   import qcv_rf_pkg::*;
#(
   parameter int DATA_W    = RF_DATA_W,
   parameter int ADDR_W    = RF_ADDR_W,
   parameter int NUM_READ  = 2,
   parameter int NUM_WRITE = 2,
   parameter int ZERO_REG  = 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   output logic                          ready_o,
   input  logic [NUM_READ*ADDR_W-1:0]    raddr_i,
   output logic [NUM_READ*DATA_W-1:0]    rdata_o,
   output logic [NUM_READ-1:0]           rbusy_o,
   input  logic [NUM_WRITE-1:0]          we_i,
   input  logic [NUM_WRITE*ADDR_W-1:0]   waddr_i,
   input  logic [NUM_WRITE*DATA_W-1:0]   wdata_i,
   input  logic                          alloc_valid_i,
   input  logic [ADDR_W-1:0]             alloc_addr_i
);

   localparam int                DEPTH      = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(ZERO_REG);

   rf_state_e         r_state;
   rf_state_e         w_stateNext;
   logic [ADDR_W-1:0] r_initCnt;
   logic [ADDR_W-1:0] w_initCntNext;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              w_ready;
   logic [NUM_READ-1:0] w_sbBusy;

   // State and INIT pointer; entry 0 is skipped when it is hardwired to zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= RF_INIT;
         r_initCnt <= FIRST_ADDR;
      end else begin
         r_state   <= w_stateNext;
         r_initCnt <= w_initCntNext;
      end
   end

   // INIT walks the pointer up to the last entry and then hands over to READY.
   always_comb begin
      w_stateNext   = r_state;
      w_initCntNext = r_initCnt;
      if (r_state == RF_INIT) begin
         w_initCntNext = r_initCnt + 1'b1;
         if (r_initCnt == LAST_ADDR) begin
            w_stateNext = RF_READY;
         end
      end
   end

   assign w_ready = (r_state == RF_READY);
   assign ready_o = w_ready;

   // Storage has no reset: INIT zeroes it one entry per cycle, READY applies
   // writes in port order so the highest-index port lands last and wins.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (r_state == RF_INIT) begin
            r_mem[r_initCnt] <= '0;
         end else begin
            for (int j = 0; j < NUM_WRITE; j++) begin
               if (we_i[j] && !(ZERO_REG != 0 && waddr_i[j*ADDR_W +: ADDR_W] == '0)) begin
                  r_mem[waddr_i[j*ADDR_W +: ADDR_W]] <= wdata_i[j*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   qcv_rf_scoreboard #(
      .ADDR_W    (ADDR_W),
      .NUM_WRITE (NUM_WRITE),
      .NUM_READ  (NUM_READ),
      .ZERO_REG  (ZERO_REG)
   ) u_scoreboard (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .en_i          (w_ready),
      .we_i          (we_i),
      .waddr_i       (waddr_i),
      .alloc_valid_i (alloc_valid_i),
      .alloc_addr_i  (alloc_addr_i),
      .raddr_i       (raddr_i),
      .rbusy_o       (w_sbBusy)
   );

   for (genvar k = 0; k < NUM_READ; k++) begin : g_read
      logic [ADDR_W-1:0] w_raddr;
      logic [DATA_W-1:0] w_rdata;
      logic              w_rbusy;

      assign w_raddr = raddr_i[k*ADDR_W +: ADDR_W];

`ifdef QCV_RF_BYPASS_EN
      logic [RF_MAX_WRITE-1:0] w_hit;
      int                      w_sel;

      // Spot the write ports hitting this read address; the zero register is
      // never bypassed so it keeps reading as zero.
      always_comb begin
         w_hit = '0;
         for (int j = 0; j < NUM_WRITE; j++) begin
            w_hit[j] = we_i[j] && (waddr_i[j*ADDR_W +: ADDR_W] == w_raddr) &&
                       !(ZERO_REG != 0 && w_raddr == '0);
         end
         w_sel = rf_write_sel(w_hit);
      end
`endif

      // Read mux: everything reads zero until INIT finishes.
      always_comb begin
         w_rdata = '0;
         w_rbusy = 1'b0;
         if (w_ready) begin
            w_rdata = r_mem[w_raddr];
            w_rbusy = w_sbBusy[k];
            if (ZERO_REG != 0 && w_raddr == '0) begin
               w_rdata = '0;
            end
`ifdef QCV_RF_BYPASS_EN
            if (w_sel >= 0) begin
               w_rdata = wdata_i[w_sel*DATA_W +: DATA_W];
               w_rbusy = 1'b0;
            end
`endif
         end
      end

      assign rdata_o[k*DATA_W +: DATA_W] = w_rdata;
      assign rbusy_o[k]                  = w_rbusy;
   end

endmodule
